mem_stage: RTL
==============

Name: mem_stage

Overview:
- MIPS pipeline memory stage, directly downstream of the execute ALU.
- Consumes the registered execute outputs: ALU result, rt data, control word, instruction, destination register and branch-taken flag.
- Performs LW/SW through a req/ack data-memory port and stalls upstream while an access is outstanding.
- Registers results toward writeback.

Parameters:
- ADDR_W, 32, data-memory address width; bit 0 is MSB, consistent with the [0:31] convention.
- TIMEOUT_CYCLES, 16, WAIT cycles before abort; used only with MEM_STAGE_TIMEOUT_EN.

Ports:
- clock  in  1  pipeline clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- aluData  in  32  execute outData: effective address or result.
- rtData  in  32  execute rtDataOut: store data.
- control  in  CONTROL_REG_SIZE  execute control_out.
- insn  in  32  execute insn_out.
- rdIn  in  5  execute rdOut.
- btIn  in  1  execute bt.
- stall  out  1  high while an access is outstanding; upstream holds all inputs stable.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (SW), 0 = read (LW).
- mem_addr  out  ADDR_W  word address, taken from aluData.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data; valid when mem_ack is high.
- mem_ack  in  1  access complete, sampled on posedge.
- wbData  out  32  result to writeback.
- rdOut  out  5  destination register to writeback.
- control_out  out  CONTROL_REG_SIZE  control word to writeback; all zero = bubble.
- insn_out  out  32  instruction to writeback.
- bt_out  out  1  registered btIn.
- wb_valid  out  1  wbData/control_out describe a real instruction.
- misaligned  out  1  one-cycle pulse on an unaligned LW/SW.
- bus_error  out  1  one-cycle pulse on access timeout.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs go to 0, including mem_req, stall, wb_valid, control_out and the timeout counter.
  - A mem_ack arriving after reset for an aborted access is ignored.
- Memory instructions: opcode insn[0:5] matches LW or SW (from alu_func.vh) and control[`I_TYPE] is set.
- State IDLE, non-memory instruction (1-cycle latency):
  - On each posedge: wbData <= aluData, rdOut <= rdIn, control_out <= control, insn_out <= insn, bt_out <= btIn.
  - wb_valid <= 1 if control is nonzero, else 0.
- State IDLE, memory instruction with aluData[30:31] != 0:
  - No request is issued.
  - misaligned <= 1 for one cycle.
  - Instruction is squashed: control_out <= 0, wb_valid <= 0.
  - State stays IDLE.
- State IDLE, aligned memory instruction:
  - mem_req <= 1, mem_addr <= aluData, mem_we <= (SW), mem_wdata <= rtData.
  - Bubble is emitted: control_out <= 0, wb_valid <= 0.
  - Next state is WAIT.
- State WAIT:
  - stall = 1 (combinational from state).
  - mem_req, mem_addr, mem_we and mem_wdata are held.
  - A bubble is emitted every cycle.
  - mem_ack is ignored in IDLE. The earliest completion is the posedge after the request edge, so the minimum memory-instruction latency is 2 cycles.
- WAIT, mem_ack = 1 at posedge:
  - mem_req <= 0.
  - wbData <= mem_rdata for LW, or aluData for SW.
  - rdOut, control_out, insn_out and bt_out are taken from the held inputs.
  - wb_valid <= 1.
  - Next state is IDLE; stall drops in the same cycle.
  - Back-to-back memory instructions therefore insert one idle edge between accesses.
- Address/data width rules:
  - mem_addr = aluData[32-ADDR_W:31].
  - No byte lanes; word accesses only.
- Simultaneous reset and mem_ack: reset wins.

Optional Feature:
- MEM_STAGE_TIMEOUT_EN defined:
  - A counter increments each WAIT cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES: mem_req <= 0, bus_error <= 1 for one cycle, the instruction is squashed (control_out <= 0, wb_valid <= 0), and the state returns to IDLE.
  - The counter clears on entry to WAIT.
  - An ack on the same edge as the timeout wins over the timeout.
- MEM_STAGE_TIMEOUT_EN undefined:
  - bus_error is tied to 0.
  - WAIT lasts until mem_ack, with no upper bound.

Decomposition:
- mem_stage.vh holds:
  - State encodings MEM_ST_IDLE = 0 and MEM_ST_WAIT = 1.
  - The alignment-mask constant.
- Opcodes come from alu_func.vh; control bit positions come from control.vh.
- One sub-module, mem_timeout_counter (enable, clear, terminal count parameter, expired output), instantiated only under MEM_STAGE_TIMEOUT_EN.

Test Plan:
- ADDU result aluData = 32'h0000_0005, rdIn = 3 → next edge wbData = 5, rdOut = 3, wb_valid = 1, stall = 0.
- LW with aluData = 32'h0000_0010, ack 3 cycles after req, mem_rdata = 32'hDEAD_BEEF → mem_req = 1 with addr 0x10 and we = 0; stall high for 3 cycles with bubbles; then wbData = DEADBEEF and wb_valid = 1.
- SW with aluData = 32'h0000_0020, rtData = 32'h1234_5678, immediate ack → mem_we = 1 and wdata = 0x12345678; completes in 2 cycles with wbData = 0x20.
- LW with aluData = 32'h0000_0013 → misaligned pulses for 1 cycle, mem_req stays 0, control_out = 0.
- Reset asserted during WAIT, then ack → mem_req and stall drop immediately without waiting for clock; the later ack produces no wb_valid.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack → bus_error pulses after 4 WAIT cycles, state returns to IDLE, and the instruction is squashed.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage: opcodes, control-word layout,
// state encoding and the word-alignment mask.
package mem_stage_pkg;

  localparam int CONTROL_REG_SIZE = 12;
  // Control-word bit that marks an I-type instruction.
  localparam int CTL_I_TYPE = 3;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_mem_insn(input logic [5:0] opcode, input logic i_type);
    return i_type && ((opcode == OP_LW) || (opcode == OP_SW));
  endfunction

  function automatic logic is_store(input logic [5:0] opcode);
    return opcode == OP_SW;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master) and the memory (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 32
);

  // Handshake: the master raises mem_req together with mem_addr/mem_we/mem_wdata
  // and holds all four unchanged until it samples mem_ack high on a posedge;
  // mem_rdata is only meaningful on that same edge. The master ignores mem_ack
  // whenever it has no request outstanding, and drops mem_req on the ack edge.
  logic              mem_req;
  logic              mem_we;
  logic [0:ADDR_W-1] mem_addr;
  logic [0:31]       mem_wdata;
  logic [0:31]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_stage_timeout_counter.sv
// Wait-cycle counter that flags an access as expired after TERMINAL cycles.
// Only built when MEM_STAGE_TIMEOUT_EN is defined.
`ifdef MEM_STAGE_TIMEOUT_EN
module mem_timeout_counter #(
  parameter int TERMINAL = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TERMINAL + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(TERMINAL))) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the edge that would complete the TERMINAL-th counted cycle.
  assign expired = enable && (count == CNT_W'(TERMINAL - 1));

endmodule
`endif

// File: rtl/mem_stage.sv
// MIPS memory stage: passes ALU results through, performs LW/SW over a req/ack
// port and stalls upstream while an access is outstanding. MEM_STAGE_TIMEOUT_EN
// adds an access timeout that aborts the instruction and pulses bus_error.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [0:31]               aluData,
  input  logic [0:31]               rtData,
  input  logic [CONTROL_REG_SIZE-1:0] control,
  input  logic [0:31]               insn,
  input  logic [0:4]                rdIn,
  input  logic                      btIn,
  output logic                      stall,
  mem_stage_if.master               mem,
  output logic [0:31]               wbData,
  output logic [0:4]                rdOut,
  output logic [CONTROL_REG_SIZE-1:0] control_out,
  output logic [0:31]               insn_out,
  output logic                      bt_out,
  output logic                      wb_valid,
  output logic                      misaligned,
  output logic                      bus_error,
  output mem_state_e                state_dbg
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_e  state;
  logic [5:0]  opcode;
  logic        mem_insn;
  logic        store_insn;
  logic        unaligned;
  logic        issue;

  assign opcode     = insn[0:5];
  assign mem_insn   = is_mem_insn(opcode, control[CTL_I_TYPE]);
  assign store_insn = is_store(opcode);
  assign unaligned  = (aluData[30:31] & ALIGN_MASK) != 2'b00;
  assign issue      = (state == MEM_ST_IDLE) && mem_insn && !unaligned;

  assign stall     = (state == MEM_ST_WAIT);
  assign state_dbg = state;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic timeout_hit;
  logic bus_error_q;

  mem_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  (stall && !mem.mem_ack),
    .clear   (issue),
    .expired (timeout_hit)
  );

  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= MEM_ST_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      wbData        <= '0;
      rdOut         <= '0;
      control_out   <= '0;
      insn_out      <= '0;
      bt_out        <= 1'b0;
      wb_valid      <= 1'b0;
      misaligned    <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      bus_error_q   <= 1'b0;
`endif
    end else begin
      misaligned <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      bus_error_q <= 1'b0;
`endif
      case (state)
        MEM_ST_IDLE: begin
          if (!mem_insn) begin
            wbData      <= aluData;
            rdOut       <= rdIn;
            control_out <= control;
            insn_out    <= insn;
            bt_out      <= btIn;
            wb_valid    <= |control;
          end else if (unaligned) begin
            misaligned  <= 1'b1;
            control_out <= '0;
            wb_valid    <= 1'b0;
          end else begin
            mem.mem_req   <= 1'b1;
            mem.mem_addr  <= aluData[32-ADDR_W:31];
            mem.mem_we    <= store_insn;
            mem.mem_wdata <= rtData;
            control_out   <= '0;
            wb_valid      <= 1'b0;
            state         <= MEM_ST_WAIT;
          end
        end

        MEM_ST_WAIT: begin
          // Upstream holds its outputs while stalled, so the live inputs still
          // describe the instruction that owns the outstanding access.
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            wbData      <= store_insn ? aluData : mem.mem_rdata;
            rdOut       <= rdIn;
            control_out <= control;
            insn_out    <= insn;
            bt_out      <= btIn;
            wb_valid    <= 1'b1;
            state       <= MEM_ST_IDLE;
          end
`ifdef MEM_STAGE_TIMEOUT_EN
          else if (timeout_hit) begin
            mem.mem_req <= 1'b0;
            bus_error_q <= 1'b1;
            control_out <= '0;
            wb_valid    <= 1'b0;
            state       <= MEM_ST_IDLE;
          end
`endif
          else begin
            control_out <= '0;
            wb_valid    <= 1'b0;
          end
        end

        default: state <= MEM_ST_IDLE;
      endcase
    end
  end

endmodule
